lcd_sink: RTL and testbench
===========================

LCD_SINK -- requirements
Module: lcd_sink

Interface
REQ-001 SHALL have port: lcdclk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: lcd_rs  input  1  register select of the observed LCD bus (0 command, 1 data).
REQ-004 SHALL have port: lcd_rw  input  1  read/write of the observed bus (0 write).
REQ-005 SHALL have port: lcd_en  input  1  enable strobe; a transfer completes on its falling edge.
REQ-006 SHALL have port: lcd_data  input  8  bus data byte.
REQ-007 SHALL have port: rd_addr  input  5  character-buffer read address (0-15 line 1, 16-31 line 2).
REQ-008 SHALL have port: rd_data  output  8  character at rd_addr, one-cycle registered latency.
REQ-009 SHALL have port: cmd_valid  output  1  one-cycle pulse per accepted command byte.
REQ-010 SHALL have port: data_valid  output  1  one-cycle pulse per accepted data byte.
REQ-011 SHALL have port: last_byte  output  8  most recently accepted byte, command or data.
REQ-012 SHALL have port: cursor  output  5  current write position in the 32-entry buffer.
REQ-013 SHALL have port: busy  output  1  high while a clear-display sweep runs.
REQ-014 SHALL have port: err_flags  output  3  sticky errors {bad_addr, read_strobe, overrun}.

Function
REQ-015 SHALL pass lcd_en, lcd_rs, lcd_rw, lcd_data through a 2-flop synchronizer; the synchronized en is edge-detected against its previous value.
REQ-016 SHALL hold rs/rw/data in capture registers loaded on every cycle the synchronized en is high; a falling edge uses the held values.
REQ-017 SHALL require en high and low each at least 3 lcdclk cycles; shorter pulses are unsupported.
REQ-018 SHALL, when a falling edge is detected in cycle N, update last_byte, cursor, buffer and pulse cmd_valid or data_valid in cycle N+1.
REQ-019 SHALL, for rw=1 strobes, ignore the transfer and set err_flags[1].
REQ-020 SHALL, for rs=1 writes, store the byte at buffer[cursor], then step cursor by +1 (I/D=1) or -1 (I/D=0), wrapping 31->0 and 0->31.
REQ-021 SHALL decode commands: 0x01 clear; 0x02/0x03 cursor=0; 0x04-0x07 latch I/D=bit1; 0x80|a set address; all others accepted with cmd_valid only.
REQ-022 SHALL map set-address a=0x00-0x0F to cursor a and a=0x40-0x4F to cursor 16+(a-0x40); any other a leaves cursor unchanged and sets err_flags[2].
REQ-023 SHALL implement FSM IDLE/CLEAR: 0x01 enters CLEAR, writes 0x20 to entries 0..31 one per cycle (32 cycles), sets cursor=0 and I/D=1, returns to IDLE; busy=1 exactly during CLEAR.
REQ-024 SHALL, on a falling edge while busy, drop the transfer (no pulse, no update) and set err_flags[0].
REQ-025 SHALL serve rd_addr from the buffer every cycle, including during CLEAR (partially cleared contents visible).

Reset
REQ-026 SHALL, on reset assertion, immediately force: cursor=0, I/D=1, FSM=IDLE, busy=0, cmd_valid=0, data_valid=0, last_byte=0x00, err_flags=0, rd_data=0x00, synchronizer and capture registers=0.
REQ-027 SHALL, on reset mid-CLEAR, abort the sweep; buffer contents are not reset and stay as left.
REQ-028 SHALL not detect a falling edge in the first cycle after reset release.

Configuration
REQ-029 SHALL, with LCD_SINK_ERR_EN defined, implement the sticky err_flags as in REQ-019/022/024, cleared only by reset.
REQ-030 SHALL, without LCD_SINK_ERR_EN, tie err_flags to 3'b000 with all other behaviour unchanged.

Verification
REQ-031 SHALL cover: after reset, cmd 0x01 -> busy high 32 cycles, rd_data=0x20 at all 32 addresses, cursor=0.
REQ-032 SHALL cover: data 0x48,0x49 -> buffer[0]=0x48, buffer[1]=0x49, cursor=2, two data_valid pulses, last_byte=0x49.
REQ-033 SHALL cover: cmd 0xC0 then data 0x41 -> buffer[16]=0x41, cursor=17; cmd 0x8F, 0x41,0x42 -> buffer[15]=0x41, buffer[16]=0x42.
REQ-034 SHALL cover: cmd 0x04, cmd 0x80, data 0x5A -> buffer[0]=0x5A, cursor=31 (wrap).
REQ-035 SHALL cover: data strobe during CLEAR -> dropped, no data_valid, err_flags=3'b001; cmd 0x90 -> err_flags=3'b101, cursor unchanged.
REQ-036 SHALL cover: rw=1 strobe -> no pulses, err_flags[1]=1; rebuilt without LCD_SINK_ERR_EN -> err_flags=0.

Source files
------------

// File: rtl/lcd_sink.sv
// Passive observer of an HD44780-style LCD bus that mirrors written characters into a 32-entry buffer.
// Optional sticky error flags are enabled with `define LCD_SINK_ERR_EN.
module lcd_sink (
    input  logic       lcdclk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic       data_valid,
    output logic [7:0] last_byte,
    output logic [4:0] cursor,
    output logic       busy,
    output logic [2:0] err_flags
);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic       en_s1_q, en_s2_q, en_prev_q;
    logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       cap_rs_q, cap_rw_q;
    logic [7:0] cap_data_q;

    state_t     state_q;
    logic       busy_q, id_q, cmd_valid_q, data_valid_q;
    logic [4:0] clr_idx_q, cursor_q;
    logic [7:0] last_byte_q, rd_data_q;
    logic [7:0] mem_q [32];

    logic       fall_d, clearing_d, accept_d, wr_data_d, wr_cmd_d;
    logic       addr_ok_d, mem_we_d;
    logic [4:0] addr_cur_d, mem_wa_d;
    logic [7:0] mem_wd_d;

    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) begin
            en_s1_q    <= 1'b0;
            en_s2_q    <= 1'b0;
            en_prev_q  <= 1'b0;
            rs_s1_q    <= 1'b0;
            rs_s2_q    <= 1'b0;
            rw_s1_q    <= 1'b0;
            rw_s2_q    <= 1'b0;
            data_s1_q  <= '0;
            data_s2_q  <= '0;
            cap_rs_q   <= 1'b0;
            cap_rw_q   <= 1'b0;
            cap_data_q <= '0;
        end else begin
            en_s1_q   <= lcd_en;
            en_s2_q   <= en_s1_q;
            en_prev_q <= en_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            data_s1_q <= lcd_data;
            data_s2_q <= data_s1_q;
            // Held while en is high so the falling edge sees the last stable bus values.
            if (en_s2_q) begin
                cap_rs_q   <= rs_s2_q;
                cap_rw_q   <= rw_s2_q;
                cap_data_q <= data_s2_q;
            end
        end
    end

    always_comb begin
        fall_d     = en_prev_q & ~en_s2_q;
        clearing_d = (state_q == CLEAR);
        accept_d   = fall_d & ~clearing_d & ~cap_rw_q;
        wr_data_d  = accept_d & cap_rs_q;
        wr_cmd_d   = accept_d & ~cap_rs_q;
        addr_ok_d  = 1'b0;
        addr_cur_d = cursor_q;
        if (cap_data_q[6:4] == 3'b000) begin
            addr_ok_d  = 1'b1;
            addr_cur_d = {1'b0, cap_data_q[3:0]};
        end else if (cap_data_q[6:4] == 3'b100) begin
            addr_ok_d  = 1'b1;
            addr_cur_d = {1'b1, cap_data_q[3:0]};
        end
        mem_we_d = clearing_d | wr_data_d;
        mem_wa_d = clearing_d ? clr_idx_q : cursor_q;
        mem_wd_d = clearing_d ? 8'h20 : cap_data_q;
    end

    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            id_q         <= 1'b1;
            clr_idx_q    <= '0;
            cursor_q     <= '0;
            cmd_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            last_byte_q  <= '0;
        end else begin
            cmd_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: ;
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 5'd1;
                    if (clr_idx_q == 5'd31) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (wr_data_d) begin
                data_valid_q <= 1'b1;
                last_byte_q  <= cap_data_q;
                cursor_q     <= id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
            end
            if (wr_cmd_d) begin
                cmd_valid_q <= 1'b1;
                last_byte_q <= cap_data_q;
                if (cap_data_q == 8'h01) begin
                    state_q   <= CLEAR;
                    busy_q    <= 1'b1;
                    clr_idx_q <= '0;
                    cursor_q  <= '0;
                    id_q      <= 1'b1;
                end else if (cap_data_q[7:1] == 7'b0000001) begin
                    cursor_q <= '0;
                end else if (cap_data_q[7:2] == 6'b000001) begin
                    id_q <= cap_data_q[1];
                end else if (cap_data_q[7] && addr_ok_d) begin
                    cursor_q <= addr_cur_d;
                end
            end
        end
    end

    // Buffer has no reset so an aborted sweep leaves its contents in place.
    always_ff @(posedge lcdclk) begin
        if (mem_we_d) mem_q[mem_wa_d] <= mem_wd_d;
    end

    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem_q[rd_addr];
    end

`ifdef LCD_SINK_ERR_EN
    logic [2:0] err_q;
    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (fall_d) begin
            if (clearing_d)                          err_q[0] <= 1'b1;
            else if (cap_rw_q)                       err_q[1] <= 1'b1;
            else if (!cap_rs_q && cap_data_q[7] && !addr_ok_d) err_q[2] <= 1'b1;
        end
    end
    assign err_flags = err_q;
`else
    assign err_flags = 3'b000;
`endif

    assign rd_data    = rd_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign data_valid = data_valid_q;
    assign last_byte  = last_byte_q;
    assign cursor     = cursor_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_sink.sv
// Directed bench for lcd_sink: vector table for normal transfers plus hand sequences for clear/error/reset cases.
module tb_lcd_sink;

`ifdef LCD_SINK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       lcdclk = 1'b0;
    logic       reset  = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data = '0;
    logic [4:0] rd_addr  = '0;
    logic [7:0] rd_data, last_byte;
    logic       cmd_valid, data_valid, busy;
    logic [4:0] cursor;
    logic [2:0] err_flags;

    int n_vec = 0;
    int n_bad = 0;
    int dv_cnt = 0;
    int cv_cnt = 0;

    lcd_sink dut (
        .lcdclk(lcdclk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .data_valid(data_valid), .last_byte(last_byte),
        .cursor(cursor), .busy(busy), .err_flags(err_flags)
    );

    always #5 lcdclk = ~lcdclk;

    always @(negedge lcdclk) begin
        if (data_valid) dv_cnt++;
        if (cmd_valid)  cv_cnt++;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] exp_cursor;
        logic [7:0] exp_last;
        int         exp_dv;
        int         exp_cv;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge lcdclk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (4) @(negedge lcdclk);
        lcd_en = 1'b0;
        repeat (4) @(negedge lcdclk);
    endtask

    task automatic start_clear();
        @(negedge lcdclk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_en = 1'b1;
        repeat (4) @(negedge lcdclk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input string name);
        for (int i = 0; i < 60 && busy !== level; i++) @(negedge lcdclk);
        chk(name, busy, level);
    endtask

    task automatic readb(input logic [4:0] a, output logic [7:0] v);
        @(negedge lcdclk);
        rd_addr = a;
        @(negedge lcdclk);
        v = rd_data;
    endtask

    initial begin
        logic [7:0] rv;
        int busy_cycles, dv0, cv0;
        logic [7:0] last0;

        vecs[0]  = '{1'b1, 8'h48, 5'd1,  8'h48, 1, 0};
        vecs[1]  = '{1'b1, 8'h49, 5'd2,  8'h49, 1, 0};
        vecs[2]  = '{1'b0, 8'hC0, 5'd16, 8'hC0, 0, 1};
        vecs[3]  = '{1'b1, 8'h41, 5'd17, 8'h41, 1, 0};
        vecs[4]  = '{1'b0, 8'h8F, 5'd15, 8'h8F, 0, 1};
        vecs[5]  = '{1'b1, 8'h41, 5'd16, 8'h41, 1, 0};
        vecs[6]  = '{1'b1, 8'h42, 5'd17, 8'h42, 1, 0};
        vecs[7]  = '{1'b0, 8'h04, 5'd17, 8'h04, 0, 1};
        vecs[8]  = '{1'b0, 8'h80, 5'd0,  8'h80, 0, 1};
        vecs[9]  = '{1'b1, 8'h5A, 5'd31, 8'h5A, 1, 0};
        vecs[10] = '{1'b0, 8'h06, 5'd31, 8'h06, 0, 1};
        vecs[11] = '{1'b1, 8'h33, 5'd0,  8'h33, 1, 0};
        vecs[12] = '{1'b0, 8'h85, 5'd5,  8'h85, 0, 1};
        vecs[13] = '{1'b0, 8'h03, 5'd0,  8'h03, 0, 1};
        vecs[14] = '{1'b0, 8'h30, 5'd0,  8'h30, 0, 1};

        repeat (3) @(negedge lcdclk);
        chk("rst_cursor", cursor, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", last_byte, 8'h00);
        chk("rst_err", err_flags, 3'b000);
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_pulses", {cmd_valid, data_valid}, 2'b00);
        reset = 1'b0;
        repeat (2) @(negedge lcdclk);

        cv0 = cv_cnt;
        start_clear();
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge lcdclk);
            if (busy) busy_cycles++;
        end
        chk("clear_busy_len", busy_cycles, 32);
        chk("clear_cv", cv_cnt - cv0, 1);
        chk("clear_cursor", cursor, 5'd0);
        for (int a = 0; a < 32; a++) begin
            readb(a[4:0], rv);
            chk($sformatf("clear_buf%0d", a), rv, 8'h20);
        end

        for (int v = 0; v < 15; v++) begin
            dv0 = dv_cnt; cv0 = cv_cnt;
            strobe(vecs[v].rs, 1'b0, vecs[v].data);
            chk($sformatf("v%0d_cursor", v), cursor, vecs[v].exp_cursor);
            chk($sformatf("v%0d_last", v), last_byte, vecs[v].exp_last);
            chk($sformatf("v%0d_dv", v), dv_cnt - dv0, vecs[v].exp_dv);
            chk($sformatf("v%0d_cv", v), cv_cnt - cv0, vecs[v].exp_cv);
        end
        readb(5'd0, rv);  chk("buf0", rv, 8'h5A);
        readb(5'd1, rv);  chk("buf1", rv, 8'h49);
        readb(5'd15, rv); chk("buf15", rv, 8'h41);
        readb(5'd16, rv); chk("buf16", rv, 8'h42);
        readb(5'd31, rv); chk("buf31", rv, 8'h33);

        // Strobe during a sweep is dropped; partial contents stay readable.
        start_clear();
        wait_busy(1'b1, "clr2_busy_rise");
        readb(5'd31, rv); chk("clr2_partial31", rv, 8'h33);
        dv0 = dv_cnt; last0 = last_byte;
        strobe(1'b1, 1'b0, 8'h77);
        chk("clr2_still_busy", busy, 1'b1);
        wait_busy(1'b0, "clr2_busy_fall");
        chk("clr2_no_dv", dv_cnt - dv0, 0);
        chk("clr2_last", last_byte, last0);
        chk("clr2_err", err_flags, ERR_EN ? 3'b001 : 3'b000);
        readb(5'd31, rv); chk("clr2_buf31", rv, 8'h20);
        readb(5'd0, rv);  chk("clr2_buf0", rv, 8'h20);

        strobe(1'b0, 1'b0, 8'h83);
        chk("seta3_cursor", cursor, 5'd3);
        strobe(1'b0, 1'b0, 8'h90);
        chk("bad_addr_cursor", cursor, 5'd3);
        chk("bad_addr_err", err_flags, ERR_EN ? 3'b101 : 3'b000);

        dv0 = dv_cnt; cv0 = cv_cnt; last0 = last_byte;
        strobe(1'b1, 1'b1, 8'h66);
        chk("rw_no_pulse", (dv_cnt - dv0) + (cv_cnt - cv0), 0);
        chk("rw_last", last_byte, last0);
        chk("rw_cursor", cursor, 5'd3);
        chk("rw_err", err_flags, ERR_EN ? 3'b111 : 3'b000);
        strobe(1'b0, 1'b1, 8'h01);
        chk("rw_no_clear", busy, 1'b0);

        strobe(1'b0, 1'b0, 8'hCA);
        strobe(1'b1, 1'b0, 8'h55);
        chk("ca_cursor", cursor, 5'd27);
        start_clear();
        wait_busy(1'b1, "clr3_busy_rise");
        repeat (5) @(negedge lcdclk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cursor", cursor, 5'd0);
        chk("midrst_last", last_byte, 8'h00);
        chk("midrst_err", err_flags, 3'b000);
        chk("midrst_rd", rd_data, 8'h00);
        @(negedge lcdclk);
        reset = 1'b0;
        repeat (3) @(negedge lcdclk);
        chk("postrst_busy", busy, 1'b0);
        readb(5'd26, rv); chk("postrst_buf26", rv, 8'h55);
        readb(5'd0, rv);  chk("postrst_buf0", rv, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
